// File: rtl/linear_table_gen_pkg.sv
// Shared scaler definitions for the linear coefficient table generator:
// unity-gain helper, index width derivation, FSM encoding and rounding helper.
package linear_table_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } gen_state_t;

  function automatic int coe_full(input int coe_width);
    return 1 << (coe_width - 1);
  endfunction

  function automatic int idx_width(input int step);
    return $clog2(step / 2);
  endfunction

  // Round half-up division by 2^lg; lg is always >= 1 because N >= 2.
  function automatic logic [63:0] round_shift(input logic [63:0] acc, input int lg);
    return (acc + (64'd1 << (lg - 1))) >> lg;
  endfunction

endpackage

// File: rtl/linear_coe_calc.sv
// Registered rounding stage: turns acc = dx*FULL into the (coe0, coe1) pair
// with coe0 + coe1 = FULL. Loads on en, otherwise holds.
module linear_coe_calc
  import linear_table_gen_pkg::*;
#(
  parameter int COE_WIDTH = 10,
  parameter int IDX_W     = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [IDX_W+COE_WIDTH-1:0] acc,
  output logic [COE_WIDTH-1:0]       coe0,
  output logic [COE_WIDTH-1:0]       coe1
);

  localparam logic [COE_WIDTH-1:0] FULL = COE_WIDTH'(coe_full(COE_WIDTH));

  logic [COE_WIDTH-1:0] c1;

  assign c1 = COE_WIDTH'(round_shift(64'(acc), IDX_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coe0 <= '0;
      coe1 <= '0;
    end else if (en) begin
      coe0 <= FULL - c1;
      coe1 <= c1;
    end
  end

endmodule

// File: rtl/linear_table_gen.sv
// Runtime generator for the linear interpolation coefficient table.
// Optional macro LINEAR_TABLE_GEN_CHECKSUM_EN adds a 32-bit sum of written coe1.
module linear_table_gen
  import linear_table_gen_pkg::*;
#(
  parameter int STEP      = 4096,
  parameter int COE_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        wr_valid,
  input  logic                        wr_ready,
  output logic [idx_width(STEP)-1:0]  wr_addr,
  output logic [COE_WIDTH-1:0]        wr_coe0,
`ifdef LINEAR_TABLE_GEN_CHECKSUM_EN
  output logic [31:0]                 checksum,
`endif
  output logic [COE_WIDTH-1:0]        wr_coe1
);

  localparam int N     = STEP / 2;
  localparam int IDX_W = idx_width(STEP);
  localparam int ACC_W = IDX_W + COE_WIDTH;
  localparam logic [ACC_W-1:0] FULL_ACC = ACC_W'(coe_full(COE_WIDTH));
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(N - 1);

  if (STEP < 4 || (STEP & (STEP - 1)) != 0) begin : g_bad_step
    $error("linear_table_gen: STEP must be a power of two and at least 4");
  end

  gen_state_t       state, next_state;
  logic [IDX_W-1:0] dx;
  logic [ACC_W-1:0] acc, acc_next;
  logic             load, adv, xfer;

  assign busy     = (state == S_RUN);
  assign wr_valid = (state == S_RUN);
  assign done     = (state == S_FIN);
  assign wr_addr  = dx;
  assign xfer     = wr_valid & wr_ready;

  always_comb begin
    next_state = state;
    load       = 1'b0;
    adv        = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        next_state = S_RUN;
        load       = 1'b1;
      end
      S_RUN: if (xfer) begin
        if (dx == LAST) next_state = S_FIN;
        else            adv        = 1'b1;
      end
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // The coefficient stage sees the next accumulator so its outputs land with dx.
  always_comb begin
    acc_next = acc;
    if (load)     acc_next = '0;
    else if (adv) acc_next = acc + FULL_ACC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      dx    <= '0;
      acc   <= '0;
    end else begin
      state <= next_state;
      acc   <= acc_next;
      if (load)     dx <= '0;
      else if (adv) dx <= dx + 1'b1;
    end
  end

  linear_coe_calc #(
    .COE_WIDTH (COE_WIDTH),
    .IDX_W     (IDX_W)
  ) u_calc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load | adv),
    .acc   (acc_next),
    .coe0  (wr_coe0),
    .coe1  (wr_coe1)
  );

`ifdef LINEAR_TABLE_GEN_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    checksum <= '0;
    else if (load) checksum <= '0;
    else if (xfer) checksum <= checksum + 32'(wr_coe1);
  end
`endif

endmodule

// File: tb/tb_linear_table_gen.sv
// Directed bench for linear_table_gen: a STEP=4096/COE_WIDTH=10 instance and a
// STEP=8/COE_WIDTH=4 instance sharing clock and reset.
module tb_linear_table_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_start, a_ready, a_busy, a_done, a_valid;
  logic [10:0] a_addr;
  logic [9:0]  a_coe0, a_coe1;
  logic        b_start, b_ready, b_busy, b_done, b_valid;
  logic [1:0]  b_addr;
  logic [3:0]  b_coe0, b_coe1;
`ifdef LINEAR_TABLE_GEN_CHECKSUM_EN
  logic [31:0] a_checksum, b_checksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  linear_table_gen #(.STEP(4096), .COE_WIDTH(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .wr_valid(a_valid), .wr_ready(a_ready), .wr_addr(a_addr), .wr_coe0(a_coe0),
`ifdef LINEAR_TABLE_GEN_CHECKSUM_EN
    .checksum(a_checksum),
`endif
    .wr_coe1(a_coe1)
  );

  linear_table_gen #(.STEP(8), .COE_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .wr_valid(b_valid), .wr_ready(b_ready), .wr_addr(b_addr), .wr_coe0(b_coe0),
`ifdef LINEAR_TABLE_GEN_CHECKSUM_EN
    .checksum(b_checksum),
`endif
    .wr_coe1(b_coe1)
  );

  // Reference: coe1 = round-half-up(dx*512/2048) for the large instance.
  function automatic int exp_c1(input int dx);
    return (dx * 512 + 1024) / 2048;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a_start();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_start = 0; a_ready = 0; b_start = 0; b_ready = 0;
    tick(); tick();
    n_checks++; if ({a_busy, a_done, a_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl_a got=%b want=000", {a_busy, a_done, a_valid}); end
    n_checks++; if (a_addr !== 11'd0) begin n_fail++; $display("FAIL reset_addr_a got=%0d want=0", a_addr); end
    n_checks++; if (a_coe0 !== 10'd0 || a_coe1 !== 10'd0) begin n_fail++; $display("FAIL reset_coe_a got=%0d/%0d want=0/0", a_coe0, a_coe1); end
    n_checks++; if ({b_busy, b_done, b_valid, b_addr, b_coe0, b_coe1} !== 13'd0) begin n_fail++; $display("FAIL reset_b got=%h want=0", {b_busy, b_done, b_valid, b_addr, b_coe0, b_coe1}); end
`ifdef LINEAR_TABLE_GEN_CHECKSUM_EN
    n_checks++; if (a_checksum !== 32'd0) begin n_fail++; $display("FAIL reset_checksum got=%0d want=0", a_checksum); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_run();
    int cyc, xfers, sum;
    bit seen;
    a_ready = 1'b1;
    pulse_a_start();
    cyc = 1; xfers = 0; seen = 0; sum = 0;
    while (!seen && cyc < 3000) begin
      if (a_valid && a_ready) begin
        n_checks++;
        if (a_addr !== 11'(xfers) || a_coe1 !== 10'(exp_c1(xfers)) || a_coe0 !== 10'(512 - exp_c1(xfers))) begin
          n_fail++; $display("FAIL full_entry addr=%0d coe0=%0d coe1=%0d want addr=%0d coe1=%0d", a_addr, a_coe0, a_coe1, xfers, exp_c1(xfers));
        end
        case (xfers)
          0:    begin n_checks++; if (a_coe0 !== 10'd512 || a_coe1 !== 10'd0) begin n_fail++; $display("FAIL spot_dx0 got=%0d/%0d want=512/0", a_coe0, a_coe1); end end
          1:    begin n_checks++; if (a_coe1 !== 10'd0) begin n_fail++; $display("FAIL spot_dx1 coe1 got=%0d want=0", a_coe1); end end
          2:    begin n_checks++; if (a_coe1 !== 10'd1) begin n_fail++; $display("FAIL spot_dx2 coe1 got=%0d want=1", a_coe1); end end
          1024: begin n_checks++; if (a_coe0 !== 10'd256 || a_coe1 !== 10'd256) begin n_fail++; $display("FAIL spot_dx1024 got=%0d/%0d want=256/256", a_coe0, a_coe1); end end
          2047: begin n_checks++; if (a_coe0 !== 10'd0 || a_coe1 !== 10'd512) begin n_fail++; $display("FAIL spot_dx2047 got=%0d/%0d want=0/512", a_coe0, a_coe1); end end
          default: ;
        endcase
        sum += exp_c1(xfers);
        xfers++;
      end
      if (a_done) seen = 1;
      else begin tick(); cyc++; end
    end
    n_checks++; if (!seen || cyc != 2049) begin n_fail++; $display("FAIL full_done_latency seen=%0d cycle=%0d want=2049", seen, cyc); end
    n_checks++; if (xfers != 2048) begin n_fail++; $display("FAIL full_xfers got=%0d want=2048", xfers); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_at_done got=%b want=0", a_busy); end
`ifdef LINEAR_TABLE_GEN_CHECKSUM_EN
    n_checks++; if (a_checksum !== 32'(sum)) begin n_fail++; $display("FAIL full_checksum got=%0d want=%0d", a_checksum, sum); end
`endif
    tick();
    n_checks++; if (a_done !== 1'b0 || a_valid !== 1'b0) begin n_fail++; $display("FAIL full_done_pulse done=%b valid=%b want=0/0", a_done, a_valid); end
  endtask

  task automatic test_random_ready();
    int cyc, xfers, bad_stall, bad_entry;
    bit seen, p_stall;
    logic [10:0] p_addr;
    logic [9:0]  p_c0, p_c1;
    cyc = 0; xfers = 0; bad_stall = 0; bad_entry = 0; seen = 0; p_stall = 0;
    p_addr = '0; p_c0 = '0; p_c1 = '0;
    a_ready = 1'b1;
    pulse_a_start();
    while (!seen && cyc < 20000) begin
      a_ready = 1'($urandom_range(0, 1));
      if (p_stall && (a_valid !== 1'b1 || a_addr !== p_addr || a_coe0 !== p_c0 || a_coe1 !== p_c1)) bad_stall++;
      if (a_valid && a_ready) begin
        if (a_addr !== 11'(xfers) || (a_coe0 + a_coe1) !== 10'd512 || a_coe1 !== 10'(exp_c1(xfers))) bad_entry++;
        xfers++;
      end
      p_stall = a_valid && !a_ready;
      p_addr = a_addr; p_c0 = a_coe0; p_c1 = a_coe1;
      if (a_done) seen = 1;
      else begin tick(); cyc++; end
    end
    a_ready = 1'b1;
    n_checks++; if (bad_stall != 0) begin n_fail++; $display("FAIL rand_stall_stable bad_cycles=%0d want=0", bad_stall); end
    n_checks++; if (bad_entry != 0) begin n_fail++; $display("FAIL rand_entries bad=%0d want=0", bad_entry); end
    n_checks++; if (!seen || xfers != 2048) begin n_fail++; $display("FAIL rand_complete done=%0d xfers=%0d want=1/2048", seen, xfers); end
    tick();
  endtask

  task automatic test_restart_ignored();
    int cyc, xfers, dones, bad;
    cyc = 0; xfers = 0; dones = 0; bad = 0;
    a_ready = 1'b1;
    pulse_a_start();
    while (dones == 0 && cyc < 3000) begin
      a_start = (a_valid && a_addr == 11'd100);
      if (a_valid) begin
        if (a_addr !== 11'(xfers)) bad++;
        xfers++;
      end
      if (a_done) dones++;
      else begin tick(); cyc++; end
    end
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    n_checks++; if (a_valid !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL start_on_done valid=%b busy=%b want=0/0", a_valid, a_busy); end
    repeat (5) begin
      if (a_done) dones++;
      tick();
    end
    n_checks++; if (bad != 0 || xfers != 2048) begin n_fail++; $display("FAIL restart_sequence bad=%0d xfers=%0d want=0/2048", bad, xfers); end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL restart_single_done got=%0d want=1", dones); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit seen;
    cyc = 0; seen = 0;
    a_ready = 1'b1;
    pulse_a_start();
    while (!(a_valid && a_addr == 11'd500) && cyc < 1000) begin tick(); cyc++; end
    n_checks++; if (a_addr !== 11'd500) begin n_fail++; $display("FAIL midrst_reach addr=%0d want=500", a_addr); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({a_busy, a_done, a_valid} !== 3'b000 || a_addr !== 11'd0 || a_coe0 !== 10'd0 || a_coe1 !== 10'd0) begin
      n_fail++; $display("FAIL midrst_outputs ctrl=%b addr=%0d coe=%0d/%0d want 000/0/0/0", {a_busy, a_done, a_valid}, a_addr, a_coe0, a_coe1);
    end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_a_start();
    n_checks++; if (a_valid !== 1'b1 || a_addr !== 11'd0 || a_coe0 !== 10'd512 || a_coe1 !== 10'd0) begin
      n_fail++; $display("FAIL midrst_restart valid=%b addr=%0d coe=%0d/%0d want 1/0/512/0", a_valid, a_addr, a_coe0, a_coe1);
    end
    cyc = 0;
    while (!seen && cyc < 3000) begin
      if (a_done) seen = 1;
      else begin tick(); cyc++; end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL midrst_finish done=0 want=1"); end
    tick();
  endtask

  task automatic test_stall();
    int cyc, bad, xfers;
    bit seen;
    bad = 0; xfers = 0; seen = 0; cyc = 1;
    a_ready = 1'b0;
    pulse_a_start();
    repeat (1000) begin
      if (a_valid !== 1'b1 || a_addr !== 11'd0 || a_busy !== 1'b1 || a_done !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold bad_cycles=%0d want=0", bad); end
    n_checks++; if (a_coe0 !== 10'd512 || a_coe1 !== 10'd0) begin n_fail++; $display("FAIL stall_data got=%0d/%0d want=512/0", a_coe0, a_coe1); end
    a_ready = 1'b1;
    while (!seen && cyc < 3000) begin
      if (a_valid) xfers++;
      if (a_done) seen = 1;
      else begin tick(); cyc++; end
    end
    n_checks++; if (!seen || xfers != 2048 || cyc != 2049) begin n_fail++; $display("FAIL stall_release done=%0d xfers=%0d cycle=%0d want=1/2048/2049", seen, xfers, cyc); end
    tick();
  endtask

  task automatic test_small_table();
    logic [3:0] e0 [4];
    logic [3:0] e1 [4];
    int cyc, xfers;
    bit seen;
    e0 = '{4'd8, 4'd6, 4'd4, 4'd2};
    e1 = '{4'd0, 4'd2, 4'd4, 4'd6};
    cyc = 1; xfers = 0; seen = 0;
    b_ready = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    while (!seen && cyc < 50) begin
      if (b_valid) begin
        n_checks++;
        if (xfers > 3 || b_addr !== 2'(xfers) || b_coe0 !== e0[xfers] || b_coe1 !== e1[xfers]) begin
          n_fail++; $display("FAIL small_entry idx=%0d addr=%0d coe=%0d/%0d", xfers, b_addr, b_coe0, b_coe1);
        end
        xfers++;
      end
      if (b_done) seen = 1;
      else begin tick(); cyc++; end
    end
    n_checks++; if (!seen || xfers != 4 || cyc != 5) begin n_fail++; $display("FAIL small_done done=%0d xfers=%0d cycle=%0d want=1/4/5", seen, xfers, cyc); end
`ifdef LINEAR_TABLE_GEN_CHECKSUM_EN
    n_checks++; if (b_checksum !== 32'd12) begin n_fail++; $display("FAIL small_checksum got=%0d want=12", b_checksum); end
    tick(); tick();
    n_checks++; if (b_checksum !== 32'd12) begin n_fail++; $display("FAIL small_checksum_hold got=%0d want=12", b_checksum); end
`else
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_random_ready();
    test_restart_ignored();
    test_reset_mid_run();
    test_stall();
    test_small_table();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
